// File: rtl/lc3_mem_pkg.sv
// Shared types and defaults for the LC-3 memory arbiter.
package lc3_mem_pkg;

    localparam int LC3_AW          = 16;
    localparam int LC3_DW          = 16;
    localparam int LC3_WAIT_CYCLES = 2;
    localparam int LC3_CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lc3_mem_state_e;

endpackage

// File: rtl/lc3_rr_arb2.sv
// Two-way round-robin pick: bit 0 is the CPU, bit 1 the debug port; grant = 1 selects debug.
module lc3_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    // Debug wins when it is alone, or on a tie when the CPU was served last.
    assign grant = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Arbitrates the CPU and debug/loader ports onto one fixed-latency memory
// using an IDLE -> ACCESS -> DONE sequence per transaction.
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = LC3_WAIT_CYCLES,
    parameter int AW          = LC3_AW,
    parameter int DW          = LC3_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          grant_dbg
);

    localparam logic [LC3_CNT_W-1:0] LAST_CNT = LC3_CNT_W'(WAIT_CYCLES - 1);

    lc3_mem_state_e       state_q, state_d;
    logic [LC3_CNT_W-1:0] cnt_q, cnt_d;
    logic                 grant_dbg_q, grant_dbg_d;
    logic                 we_q, we_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [DW-1:0]        cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]        dbg_rdata_q, dbg_rdata_d;
    logic                 arb_grant;

    lc3_rr_arb2 u_arb (
        .req   ({dbg_req, cpu_req}),
        .last  (grant_dbg_q),
        .grant (arb_grant)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_dbg_d = grant_dbg_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req || dbg_req) begin
                    state_d     = ST_ACCESS;
                    cnt_d       = '0;
                    grant_dbg_d = arb_grant;
                    we_d        = arb_grant ? dbg_we    : cpu_we;
                    addr_d      = arb_grant ? dbg_addr  : cpu_addr;
                    wdata_d     = arb_grant ? dbg_wdata : cpu_wdata;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    // Read data is only valid in the final access cycle.
                    if (!we_q) begin
                        if (grant_dbg_q) dbg_rdata_d = mem_rdata;
                        else             cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            grant_dbg_q <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_dbg_q <= grant_dbg_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ready = (state_q == ST_DONE) & ~grant_dbg_q;
    assign dbg_ready = (state_q == ST_DONE) &  grant_dbg_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign grant_dbg = grant_dbg_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: transaction-level reference model plus directed scenarios.
module tb_lc3_mem_arbiter;

    localparam int W = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main DUT stimulus: index 0 = CPU port, 1 = debug port
    logic [1:0]  p_req;
    logic [1:0]  p_we;
    logic [15:0] p_addr  [2];
    logic [15:0] p_wdata [2];

    logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ready, dbg_ready, mem_en, mem_we, grant_dbg;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] ref_rdata [2];
    bit          ref_last;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] = mem_wdata;

    lc3_mem_arbiter #(.WAIT_CYCLES(W), .AW(16), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(p_req[0]), .cpu_we(p_we[0]), .cpu_addr(p_addr[0]), .cpu_wdata(p_wdata[0]),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dbg_req(p_req[1]), .dbg_we(p_we[1]), .dbg_addr(p_addr[1]), .dbg_wdata(p_wdata[1]),
        .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant_dbg(grant_dbg)
    );

    // Parameter-sweep instances, CPU port only; memory returns the inverted address
    logic        s1_req, s15_req, zero_b;
    logic [15:0] s_addr, s_wdata, zero_w;
    logic [15:0] s1_rdata, s1_drdata, s1_maddr, s1_mwdata;
    logic [15:0] s15_rdata, s15_drdata, s15_maddr, s15_mwdata;
    logic        s1_rdy, s1_drdy, s1_en, s1_we, s1_gd;
    logic        s15_rdy, s15_drdy, s15_en, s15_we, s15_gd;
    assign zero_b = 1'b0;
    assign zero_w = 16'h0000;

    lc3_mem_arbiter #(.WAIT_CYCLES(1), .AW(16), .DW(16)) u_w1 (
        .clk(clk), .reset(reset),
        .cpu_req(s1_req), .cpu_we(zero_b), .cpu_addr(s_addr), .cpu_wdata(s_wdata),
        .cpu_rdata(s1_rdata), .cpu_ready(s1_rdy),
        .dbg_req(zero_b), .dbg_we(zero_b), .dbg_addr(zero_w), .dbg_wdata(zero_w),
        .dbg_rdata(s1_drdata), .dbg_ready(s1_drdy),
        .mem_en(s1_en), .mem_we(s1_we), .mem_addr(s1_maddr), .mem_wdata(s1_mwdata),
        .mem_rdata(~s1_maddr), .grant_dbg(s1_gd)
    );

    lc3_mem_arbiter #(.WAIT_CYCLES(15), .AW(16), .DW(16)) u_w15 (
        .clk(clk), .reset(reset),
        .cpu_req(s15_req), .cpu_we(zero_b), .cpu_addr(s_addr), .cpu_wdata(s_wdata),
        .cpu_rdata(s15_rdata), .cpu_ready(s15_rdy),
        .dbg_req(zero_b), .dbg_we(zero_b), .dbg_addr(zero_w), .dbg_wdata(zero_w),
        .dbg_rdata(s15_drdata), .dbg_ready(s15_drdy),
        .mem_en(s15_en), .mem_we(s15_we), .mem_addr(s15_maddr), .mem_wdata(s15_mwdata),
        .mem_rdata(~s15_maddr), .grant_dbg(s15_gd)
    );

    task automatic model_reset();
        ref_last     = 1'b1;
        ref_rdata[0] = 16'h0000;
        ref_rdata[1] = 16'h0000;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        p_req = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One transaction (or a colliding pair) from an idle arbiter, checked cycle by cycle.
    // Expected timing: winner ready at W+1; a waiting loser is granted after one
    // idle bubble and becomes ready at 2W+3.
    task automatic run_txn(input bit rq0, input bit rq1, input bit we0, input bit we1,
                           input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input bit scramble, input bit drop_early);
        int first, second, t1, t2, total;
        bit both;
        logic [15:0] ta [2];
        logic [15:0] td [2];
        bit tw [2];
        both = rq0 && rq1;
        if (both) first = ref_last ? 0 : 1;
        else      first = rq1 ? 1 : 0;
        second = 1 - first;
        t1 = W + 1;
        t2 = both ? 2 * W + 3 : -100;
        total = both ? t2 : t1;
        ta[0] = a0; ta[1] = a1; td[0] = d0; td[1] = d1; tw[0] = we0; tw[1] = we1;
        p_addr[0] = a0; p_addr[1] = a1; p_wdata[0] = d0; p_wdata[1] = d1;
        p_we = {we1, we0};
        p_req = {rq1, rq0};
        for (int c = 0; c <= total + 1; c++) begin
            int owner;
            bit exp_en, exp_cr, exp_dr;
            exp_en = (c >= 1 && c <= W) || (both && c >= W + 3 && c <= 2 * W + 2);
            owner  = (both && c >= W + 3) ? second : first;
            exp_cr = (first == 0 && c == t1) || (second == 0 && c == t2);
            exp_dr = (first == 1 && c == t1) || (second == 1 && c == t2);
            if (c == t1 || c == t2) begin
                int k;
                k = (c == t1) ? first : second;
                if (tw[k]) ref_mem[ta[k]] = td[k];
                else       ref_rdata[k] = ref_mem[ta[k]];
            end
            @(negedge clk);
            checks += 5;
            if (cpu_ready !== exp_cr) begin errors++; $display("FAIL cpu_ready c=%0d got %b exp %b", c, cpu_ready, exp_cr); end
            if (dbg_ready !== exp_dr) begin errors++; $display("FAIL dbg_ready c=%0d got %b exp %b", c, dbg_ready, exp_dr); end
            if (mem_en !== exp_en) begin errors++; $display("FAIL mem_en c=%0d got %b exp %b", c, mem_en, exp_en); end
            if (cpu_rdata !== ref_rdata[0]) begin errors++; $display("FAIL cpu_rdata c=%0d got %h exp %h", c, cpu_rdata, ref_rdata[0]); end
            if (dbg_rdata !== ref_rdata[1]) begin errors++; $display("FAIL dbg_rdata c=%0d got %h exp %h", c, dbg_rdata, ref_rdata[1]); end
            if (c == 0) begin
                checks++;
                if (grant_dbg !== ref_last) begin errors++; $display("FAIL grant_dbg_idle got %b exp %b", grant_dbg, ref_last); end
            end else begin
                checks += 4;
                if (mem_addr !== ta[owner]) begin errors++; $display("FAIL mem_addr c=%0d got %h exp %h", c, mem_addr, ta[owner]); end
                if (mem_wdata !== td[owner]) begin errors++; $display("FAIL mem_wdata c=%0d got %h exp %h", c, mem_wdata, td[owner]); end
                if (mem_we !== (exp_en && tw[owner])) begin errors++; $display("FAIL mem_we c=%0d got %b exp %b", c, mem_we, exp_en && tw[owner]); end
                if (grant_dbg !== 1'(owner)) begin errors++; $display("FAIL grant_dbg c=%0d got %b exp %0d", c, grant_dbg, owner); end
            end
            @(posedge clk); #1;
            if (drop_early && c == 0) p_req[first] = 1'b0;
            if (c == t1) p_req[first] = 1'b0;
            if (c == t2) p_req[second] = 1'b0;
            if (scramble && c + 1 <= t1) begin
                p_addr[first]  = 16'($urandom);
                p_wdata[first] = 16'($urandom);
                p_we[first]    = 1'($urandom);
            end
        end
        ref_last = both ? 1'(second) : 1'(first);
    endtask

    task automatic test_reset();
        p_req = 2'b00; p_we = 2'b00;
        p_addr[0] = 16'h0; p_addr[1] = 16'h0; p_wdata[0] = 16'h0; p_wdata[1] = 16'h0;
        s1_req = 1'b0; s15_req = 1'b0; s_addr = 16'h0; s_wdata = 16'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            checks += 9;
            if (mem_en !== 1'b0)          begin errors++; $display("FAIL rst_mem_en pass=%0d got %b exp 0", pass, mem_en); end
            if (mem_we !== 1'b0)          begin errors++; $display("FAIL rst_mem_we pass=%0d got %b exp 0", pass, mem_we); end
            if (cpu_ready !== 1'b0)       begin errors++; $display("FAIL rst_cpu_ready pass=%0d got %b exp 0", pass, cpu_ready); end
            if (dbg_ready !== 1'b0)       begin errors++; $display("FAIL rst_dbg_ready pass=%0d got %b exp 0", pass, dbg_ready); end
            if (mem_addr !== 16'h0)       begin errors++; $display("FAIL rst_mem_addr pass=%0d got %h exp 0", pass, mem_addr); end
            if (mem_wdata !== 16'h0)      begin errors++; $display("FAIL rst_mem_wdata pass=%0d got %h exp 0", pass, mem_wdata); end
            if (cpu_rdata !== 16'h0)      begin errors++; $display("FAIL rst_cpu_rdata pass=%0d got %h exp 0", pass, cpu_rdata); end
            if (dbg_rdata !== 16'h0)      begin errors++; $display("FAIL rst_dbg_rdata pass=%0d got %h exp 0", pass, dbg_rdata); end
            if (grant_dbg !== 1'b1)       begin errors++; $display("FAIL rst_grant_dbg pass=%0d got %b exp 1", pass, grant_dbg); end
            reset = 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_read();
        mem[16'h3000] = 16'h1234;
        ref_mem[16'h3000] = 16'h1234;
        run_txn(1, 0, 0, 0, 16'h3000, 16'h0, 16'h0, 16'h0, 0, 0);
        checks++;
        if (cpu_rdata !== 16'h1234) begin errors++; $display("FAIL cpu_read_data got %h exp 1234", cpu_rdata); end
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        run_txn(1, 1, 0, 0, 16'h3001, 16'h3002, 16'h0, 16'h0, 0, 0);
    endtask

    task automatic test_dbg_write();
        logic [15:0] old_dbg;
        old_dbg = dbg_rdata;
        run_txn(0, 1, 0, 1, 16'h0, 16'h0200, 16'h0, 16'hBEEF, 0, 0);
        run_txn(1, 0, 0, 0, 16'h0200, 16'h0, 16'h0, 16'h0, 0, 0);
        checks += 2;
        if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL dbg_write_readback got %h exp beef", cpu_rdata); end
        if (dbg_rdata !== old_dbg)  begin errors++; $display("FAIL dbg_write_rdata_kept got %h exp %h", dbg_rdata, old_dbg); end
    endtask

    task automatic test_input_change();
        run_txn(1, 0, 0, 0, 16'h3003, 16'h0, 16'h0, 16'h0, 1, 1);
        run_txn(0, 1, 1, 0, 16'h0, 16'h0204, 16'h0, 16'h55AA, 1, 0);
    endtask

    task automatic test_reset_mid_access();
        p_addr[0] = 16'h3005; p_we[0] = 1'b0; p_req = 2'b01;
        @(posedge clk); #1;
        checks++;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL mid_rst_pre_en got %b exp 1", mem_en); end
        reset = 1'b1;
        p_req = 2'b00;
        #1;
        checks += 4;
        if (mem_en !== 1'b0)     begin errors++; $display("FAIL mid_rst_en got %b exp 0", mem_en); end
        if (cpu_ready !== 1'b0)  begin errors++; $display("FAIL mid_rst_ready got %b exp 0", cpu_ready); end
        if (mem_addr !== 16'h0)  begin errors++; $display("FAIL mid_rst_addr got %h exp 0", mem_addr); end
        if (grant_dbg !== 1'b1)  begin errors++; $display("FAIL mid_rst_grant got %b exp 1", grant_dbg); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks += 3;
            if (cpu_ready !== 1'b0) begin errors++; $display("FAIL post_rst_cpu_ready c=%0d got %b exp 0", c, cpu_ready); end
            if (dbg_ready !== 1'b0) begin errors++; $display("FAIL post_rst_dbg_ready c=%0d got %b exp 0", c, dbg_ready); end
            if (mem_en !== 1'b0)    begin errors++; $display("FAIL post_rst_en c=%0d got %b exp 0", c, mem_en); end
        end
        @(posedge clk); #1;
        run_txn(1, 0, 0, 0, 16'h3005, 16'h0, 16'h0, 16'h0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int sel;
            logic [15:0] a0, a1;
            sel = $urandom_range(1, 3);
            a0 = ($urandom_range(0, 1) ? 16'h3000 : 16'h0200) + 16'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 1) ? 16'h3000 : 16'h0200) + 16'($urandom_range(0, 7));
            run_txn(sel[0], sel[1], 1'($urandom), 1'($urandom), a0, a1,
                    16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    task automatic test_param_sweep();
        int r1, r15, extra;
        r1 = -1; r15 = -1; extra = 0;
        s_addr = 16'($urandom); s_wdata = 16'($urandom);
        s1_req = 1'b1; s15_req = 1'b1;
        for (int c = 0; c <= 24; c++) begin
            @(negedge clk);
            checks += 8;
            if (s1_en !== (c == 1))            begin errors++; $display("FAIL w1_en c=%0d got %b", c, s1_en); end
            if (s15_en !== (c >= 1 && c <= 15)) begin errors++; $display("FAIL w15_en c=%0d got %b", c, s15_en); end
            if ((s1_we | s15_we | s1_drdy | s15_drdy) !== 1'b0) begin errors++; $display("FAIL sweep_we_drdy c=%0d got %b%b%b%b exp 0000", c, s1_we, s15_we, s1_drdy, s15_drdy); end
            if ((s1_drdata | s15_drdata) !== 16'h0) begin errors++; $display("FAIL sweep_dbg_rdata c=%0d got %h/%h exp 0", c, s1_drdata, s15_drdata); end
            if (c >= 1 && s1_maddr !== s_addr)   begin errors++; $display("FAIL w1_addr c=%0d got %h exp %h", c, s1_maddr, s_addr); end
            if (c >= 1 && s15_mwdata !== s_wdata) begin errors++; $display("FAIL w15_wdata c=%0d got %h exp %h", c, s15_mwdata, s_wdata); end
            if (c >= 1 && (s1_gd | s15_gd) !== 1'b0) begin errors++; $display("FAIL sweep_grant c=%0d got %b/%b exp 0", c, s1_gd, s15_gd); end
            if (c >= 1 && (s15_maddr !== s_addr || s1_mwdata !== s_wdata)) begin errors++; $display("FAIL sweep_latch c=%0d got %h/%h", c, s15_maddr, s1_mwdata); end
            if (s1_rdy)  begin if (r1 < 0) r1 = c; else extra++; end
            if (s15_rdy) begin if (r15 < 0) r15 = c; else extra++; end
            @(posedge clk); #1;
            if (r1 >= 0)  s1_req = 1'b0;
            if (r15 >= 0) s15_req = 1'b0;
        end
        checks += 5;
        if (r1 != 2)   begin errors++; $display("FAIL w1_latency got %0d exp 2", r1); end
        if (r15 != 16) begin errors++; $display("FAIL w15_latency got %0d exp 16", r15); end
        if (extra != 0) begin errors++; $display("FAIL sweep_extra_ready got %0d exp 0", extra); end
        if (s1_rdata !== ~s_addr)  begin errors++; $display("FAIL w1_rdata got %h exp %h", s1_rdata, ~s_addr); end
        if (s15_rdata !== ~s_addr) begin errors++; $display("FAIL w15_rdata got %h exp %h", s15_rdata, ~s_addr); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i * 7 + 3);
            ref_mem[i] = 16'(i * 7 + 3);
        end
        test_reset();
        test_cpu_read();
        test_simultaneous();
        test_dbg_write();
        test_input_change();
        test_reset_mid_access();
        test_random();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
